// File: rtl/stopwatch_pkg.sv
// Purpose: shared types and constants for the stopwatch control front end and core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    // Control FSM encoding; the raw value is also exported as a debug/LED field.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        HOLD = 2'd3
    } fsm_e;

    // Run/pause level as understood by the stopwatch core.
    localparam logic PAUSE   = 1'b0;
    localparam logic RUNNING = 1'b1;

    // 10 ms of stability at 50 MHz before a button level is believed.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: condition one raw pushbutton: 2-flop sync, debounce, rising-edge pulse.
// Latency: input first sampled at edge 0 -> rise asserted after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; the pulse is one clock wide and must be consumed when it occurs.
//
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   btn_raw  in  raw button level, asynchronous to clk
//   rise     out one-clock pulse when the debounced level goes 0->1
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES  // must be >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        // Any clock where the synced input agrees with the accepted level
        // restarts the count, so only an unbroken run of disagreement wins.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Edge taken from the registered level so the pulse lands one clock
        // after the level itself changes.
        rise_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Purpose: stopwatch button front end: two conditioned buttons drive a run/lap/hold FSM.
// Latency: button first sampled at edge 0 -> outputs update after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; every button event is acted on in the clock it arrives.
//
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   btn_start  in  raw start/stop button, active-high, asynchronous
//   btn_lap    in  raw lap/clear button, active-high, asynchronous
//   state      out 0 = pause, 1 = running (core run input)
//   lap_hold   out 1 = display frozen at the lap instant
//   clear      out one-clock pulse to zero the time counters
//   fsm_state  out current FSM encoding (debug/LED)
module stopwatch_btn_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       state,
    output logic       lap_hold,
    output logic       clear,
    output logic [1:0] fsm_state
);

    logic start_rise;
    logic lap_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_start),
        .rise    (start_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_lap),
        .rise    (lap_rise)
    );

    fsm_e fsm_q, fsm_d;
    logic state_q, state_d;
    logic lap_hold_q, lap_hold_d;
    logic clear_q, clear_d;

    // Start is tested first everywhere, so a lap event in the same clock is dropped.
    always_comb begin
        fsm_d   = fsm_q;
        clear_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_rise) fsm_d = RUN;
            end
            RUN: begin
                if (start_rise)    fsm_d = HOLD;
                else if (lap_rise) fsm_d = LAP;
            end
            LAP: begin
                if (start_rise)    fsm_d = HOLD;
                else if (lap_rise) fsm_d = RUN;
            end
            HOLD: begin
                if (start_rise) begin
                    fsm_d = RUN;
                end else if (lap_rise) begin
                    fsm_d   = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Outputs decoded from the next state so they change on the same edge as the FSM.
        state_d    = ((fsm_d == RUN) || (fsm_d == LAP)) ? RUNNING : PAUSE;
        lap_hold_d = (fsm_d == LAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= IDLE;
            state_q    <= PAUSE;
            lap_hold_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            lap_hold_q <= lap_hold_d;
            clear_q    <= clear_d;
        end
    end

    assign state     = state_q;
    assign lap_hold  = lap_hold_q;
    assign clear     = clear_q;
    assign fsm_state = fsm_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Purpose: self-checking bench for stopwatch_btn_ctrl with a short debounce window.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_btn_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       state, lap_hold, clear;
    logic [1:0] fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    stopwatch_btn_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .state     (state),
        .lap_hold  (lap_hold),
        .clear     (clear),
        .fsm_state (fsm_state)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per button: the value seen at edge n is the raw value from edge n-2;
    // a level is accepted after D consecutive disagreeing samples; the FSM
    // sees the acceptance as an event two edges later.
    int         m_run[2];
    bit         m_lvl[2];
    bit         m_raw_dly[2][2];
    bit         m_ev_dly[2][2];
    logic [1:0] m_fsm = 2'd0;
    bit         m_clear = 1'b0;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_run[b] = 0;
            m_lvl[b] = 1'b0;
            m_raw_dly[b][0] = 1'b0; m_raw_dly[b][1] = 1'b0;
            m_ev_dly[b][0]  = 1'b0; m_ev_dly[b][1]  = 1'b0;
        end
        m_fsm   = 2'd0;
        m_clear = 1'b0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            bit raw[2];
            bit ev[2];
            bit seen;
            raw[0] = btn_start;
            raw[1] = btn_lap;
            for (int b = 0; b < 2; b++) begin
                seen = m_raw_dly[b][0];
                m_raw_dly[b][0] = m_raw_dly[b][1];
                m_raw_dly[b][1] = raw[b];
                ev[b] = m_ev_dly[b][0];
                m_ev_dly[b][0] = m_ev_dly[b][1];
                m_ev_dly[b][1] = 1'b0;
                if (seen != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_lvl[b] = seen;
                        m_run[b] = 0;
                        m_ev_dly[b][1] = seen;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_clear = 1'b0;
            if (ev[0]) begin
                m_fsm = (m_fsm == 2'd1 || m_fsm == 2'd2) ? 2'd3 : 2'd1;
            end else if (ev[1]) begin
                case (m_fsm)
                    2'd1: m_fsm = 2'd2;
                    2'd2: m_fsm = 2'd1;
                    2'd3: begin m_fsm = 2'd0; m_clear = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] exp_v, act_v;
            exp_v = {m_fsm, (m_fsm == 2'd1 || m_fsm == 2'd2), (m_fsm == 2'd2), m_clear};
            act_v = {fsm_state, state, lap_hold, clear};
            check("model_cmp", 8'(act_v), 8'(exp_v));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input bit s, input bit l, input int hold, input int total);
        @(posedge clk); #1;
        btn_start = s;
        btn_lap   = l;
        repeat (hold) @(posedge clk);
        #1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (total - hold) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         s;
        bit         l;
        int         hold;
        logic [1:0] fsm;
        bit         st;
        bit         lh;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int cnt;
        logic [1:0] prev;
        bit bounce[4];

        vecs[0]  = '{1'b0, 1'b1, 6, 2'd0, 1'b0, 1'b0};  // lap ignored in IDLE
        vecs[1]  = '{1'b1, 1'b0, 6, 2'd1, 1'b1, 1'b0};  // IDLE -> RUN
        vecs[2]  = '{1'b1, 1'b0, 3, 2'd1, 1'b1, 1'b0};  // 3-clock glitch: nothing
        vecs[3]  = '{1'b0, 1'b1, 6, 2'd2, 1'b1, 1'b1};  // RUN -> LAP
        vecs[4]  = '{1'b0, 1'b1, 6, 2'd1, 1'b1, 1'b0};  // LAP -> RUN
        vecs[5]  = '{1'b0, 1'b1, 6, 2'd2, 1'b1, 1'b1};  // RUN -> LAP
        vecs[6]  = '{1'b1, 1'b0, 6, 2'd3, 1'b0, 1'b0};  // LAP -> HOLD
        vecs[7]  = '{1'b1, 1'b0, 6, 2'd1, 1'b1, 1'b0};  // HOLD -> RUN
        vecs[8]  = '{1'b1, 1'b1, 6, 2'd3, 1'b0, 1'b0};  // both in RUN: start wins
        vecs[9]  = '{1'b0, 1'b1, 6, 2'd0, 1'b0, 1'b0};  // HOLD -> IDLE
        vecs[10] = '{1'b0, 1'b1, 6, 2'd0, 1'b0, 1'b0};  // lap ignored in IDLE
        vecs[11] = '{1'b1, 1'b1, 6, 2'd1, 1'b1, 1'b0};  // both in IDLE: RUN
        vecs[12] = '{1'b1, 1'b0, 6, 2'd3, 1'b0, 1'b0};  // RUN -> HOLD

        // Reset, then idle with no buttons.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", 8'({fsm_state, state, lap_hold, clear}), 8'd0);
        end

        // Exact press-to-output latency.
        @(posedge clk); #1 btn_start = 1'b1;
        repeat (D + 3) @(posedge clk);            // edges 0..D+2
        @(negedge clk);
        check("latency_before", 8'(state), 8'd0);
        @(posedge clk);                           // edge D+3
        @(negedge clk);
        check("latency_state", 8'(state), 8'd1);
        check("latency_fsm", 8'(fsm_state), 8'd1);
        repeat (12) @(posedge clk);
        #1 btn_start = 1'b0;
        repeat (20) @(negedge clk);
        check("release_no_change", 8'({fsm_state, state}), 8'({2'd1, 1'b1}));
        press(1'b1, 1'b0, 20, 30);
        check("second_press", 8'({fsm_state, state}), 8'({2'd3, 1'b0}));

        // HOLD -> IDLE: clear must be high for exactly one clock.
        cnt = 0;
        @(posedge clk); #1 btn_lap = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (clear) cnt++;
            if (i == 8) btn_lap = 1'b0;
        end
        check("clear_width", 8'(cnt), 8'd1);
        check("clear_to_idle", 8'({fsm_state, state}), 8'd0);

        // Bouncing press: exactly one FSM transition.
        bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b0;
        cnt  = 0;
        prev = fsm_state;
        for (int i = 0; i < 45; i++) begin
            if (i < 8)       btn_start = bounce[i / 2];
            else if (i < 18) btn_start = 1'b1;
            else             btn_start = 1'b0;
            @(negedge clk);
            if (fsm_state != prev) cnt++;
            prev = fsm_state;
        end
        check("bounce_transitions", 8'(cnt), 8'd1);
        check("bounce_fsm", 8'(fsm_state), 8'd1);

        // Lone 3-clock glitch: no transition.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            btn_start = (i < 3);
            @(negedge clk);
            if (fsm_state != prev) cnt++;
            prev = fsm_state;
        end
        check("glitch_transitions", 8'(cnt), 8'd0);

        // Reset while in LAP with start mid-debounce.
        press(1'b0, 1'b1, 6, 16);
        check("enter_lap", 8'({fsm_state, state, lap_hold}), 8'({2'd2, 1'b1, 1'b1}));
        @(posedge clk); #1 btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("reset_immediate", 8'({fsm_state, state, lap_hold, clear}), 8'd0);
        btn_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(negedge clk);
        check("after_reset_idle", 8'({fsm_state, state, lap_hold, clear}), 8'd0);

        // Table-driven vectors, starting from IDLE.
        foreach (vecs[i]) begin
            press(vecs[i].s, vecs[i].l, vecs[i].hold, 16);
            check($sformatf("vec%0d", i),
                  8'({fsm_state, state, lap_hold, clear}),
                  8'({vecs[i].fsm, vecs[i].st, vecs[i].lh, 1'b0}));
        end

        // Random button activity against the model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            btn_start = 1'($urandom_range(0, 1));
            btn_lap   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
